// File: rtl/kbd_mmio_if.sv
// CPU data-port view of the keyboard register window.
// Valid/ready: a request is taken on any cycle with sel=1 and stall_in=0; kbd_data_out is valid in that same cycle.
interface kbd_mmio_if;
  logic        sel;
  logic        dmem_read_in;
  logic        dmem_write_in;
  logic [29:0] dmem_addr;
  logic [31:0] data_from_reg;
  logic        stall_in;
  logic [31:0] kbd_data_out;

  modport master (
    output sel, dmem_read_in, dmem_write_in, dmem_addr, data_from_reg, stall_in,
    input  kbd_data_out
  );

  modport slave (
    input  sel, dmem_read_in, dmem_write_in, dmem_addr, data_from_reg, stall_in,
    output kbd_data_out
  );
endinterface

// File: rtl/kbd_mmio.sv
// PS/2 keyboard receiver with a scan-code FIFO behind a four-word MMIO window.
// Frames are deserialised on synchronised ps2_clk falls; good bytes are queued for CPU loads.
module kbd_mmio #(
  parameter int FIFO_AW = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  kbd_mmio_if.slave  bus,
  output logic       irq,
  output logic [2:0] dbg_state_o
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAR, S_STOP, S_CHECK} state_e;

  logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q, ps2d_s1_q, ps2d_s2_q;
  logic fall;

  state_e        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitcnt_q;
  logic          par_q;
  logic          stop_q;
  logic [TW-1:0] tmo_q;
  logic          timed_out;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               ovf_q, perr_q, ferr_q, irq_q;

  logic        empty, full, acc, pop, ctrl_wr, flush, parity_ok;
  logic        push_req, perr_set, ferr_set, do_push, ovf_set;
  logic [31:0] status, rd_data;
  logic        unused_bits;

  // Reset to 1 so an idle-high line never looks like a fall on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2c_s1_q   <= 1'b1;
      ps2c_s2_q   <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_s1_q   <= 1'b1;
      ps2d_s2_q   <= 1'b1;
    end else begin
      ps2c_s1_q   <= ps2_clk;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= ps2_data;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign fall      = ps2c_prev_q & ~ps2c_s2_q;
  assign timed_out = (state_q inside {S_DATA, S_PAR, S_STOP}) && !fall &&
                     (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      stop_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      if (state_q == S_IDLE || state_q == S_CHECK || fall) tmo_q <= '0;
      else                                                 tmo_q <= tmo_q + 1'b1;
      unique case (state_q)
        S_IDLE: if (fall && !ps2d_s2_q) begin
          state_q  <= S_DATA;
          bitcnt_q <= '0;
        end
        S_DATA: if (fall) begin
          shift_q  <= {ps2d_s2_q, shift_q[7:1]};
          bitcnt_q <= bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_q <= S_PAR;
        end
        S_PAR: if (fall) begin
          par_q   <= ps2d_s2_q;
          state_q <= S_STOP;
        end
        S_STOP: if (fall) begin
          stop_q  <= ps2d_s2_q;
          state_q <= S_CHECK;
        end
        S_CHECK: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (timed_out) begin
        state_q <= S_IDLE;
        tmo_q   <= '0;
      end
    end
  end

  assign parity_ok = ^{shift_q, par_q};
  assign push_req  = (state_q == S_CHECK) &  stop_q &  parity_ok;
  assign perr_set  = (state_q == S_CHECK) &  stop_q & ~parity_ok;
  assign ferr_set  = (state_q == S_CHECK) & ~stop_q;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign acc     = bus.sel & ~bus.stall_in;
  assign pop     = acc & bus.dmem_read_in & (bus.dmem_addr[1:0] == 2'd0) & ~empty;
  assign ctrl_wr = acc & bus.dmem_write_in & (bus.dmem_addr[1:0] == 2'd2);
  assign flush   = ctrl_wr & bus.data_from_reg[0];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign do_push = push_req & (~full | pop) & ~flush;
  assign ovf_set = push_req & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_q  <= ~empty;
      ovf_q  <= ovf_set  | (ovf_q  & ~(ctrl_wr & bus.data_from_reg[1]));
      perr_q <= perr_set | (perr_q & ~(ctrl_wr & bus.data_from_reg[2]));
      ferr_q <= ferr_set | (ferr_q & ~(ctrl_wr & bus.data_from_reg[3]));
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) wptr_q <= wptr_q + 1'b1;
        if (pop)     rptr_q <= rptr_q + 1'b1;
        unique case ({do_push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status                  = '0;
    status[0]               = ~empty;
    status[1]               = full;
    status[2]               = ovf_q;
    status[3]               = perr_q;
    status[4]               = ferr_q;
    status[16 +: FIFO_AW+1] = count_q;
    rd_data                 = '0;
    if (bus.sel && bus.dmem_read_in) begin
      unique case (bus.dmem_addr[1:0])
        2'd0:    rd_data = empty ? 32'd0 : {23'd0, 1'b1, mem_q[rptr_q]};
        2'd1:    rd_data = status;
        default: rd_data = '0;
      endcase
    end
  end

  assign bus.kbd_data_out = rd_data;
  assign irq              = irq_q;
  assign dbg_state_o      = state_q;
  assign unused_bits      = ^{bus.dmem_addr[29:2], bus.data_from_reg[31:4]};
endmodule

// File: tb/tb_kbd_mmio.sv
// Bench for kbd_mmio: directed scenarios plus random frames and bus traffic,
// checked every cycle against a queue-based model of the register window.
module tb_kbd_mmio;
  localparam int TMO = 20000;
  localparam int H   = 4;

  logic       clk;
  logic       rst_n;
  logic       ps2c, ps2d;
  logic       irq;
  logic [2:0] dbg_state;

  kbd_mmio_if bus ();

  kbd_mmio #(.FIFO_AW(4), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .ps2_clk     (ps2c),
    .ps2_data    (ps2d),
    .bus         (bus),
    .irq         (irq),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int         edge_n;
    int         kind;   // 0 good byte, 1 parity error, 2 framing error
    logic [7:0] b;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] exp_q[$];
  bit         m_ovf, m_perr, m_ferr, m_irq;
  int         cyc;
  int         n_vec, n_mis;
  bit         frames_done;

  always @(posedge clk or negedge rst_n) begin : model
    int sz;
    bit acc, pop, cwr, flush, push;
    bit s_ovf, s_perr, s_ferr;
    if (!rst_n) begin
      exp_q.delete();
      ev_q.delete();
      m_ovf  = 0;
      m_perr = 0;
      m_ferr = 0;
      m_irq  = 0;
    end else begin
      cyc++;
      sz     = exp_q.size();
      m_irq  = (sz != 0);
      acc    = bus.sel && !bus.stall_in;
      pop    = acc && bus.dmem_read_in && bus.dmem_addr[1:0] == 2'd0 && sz > 0;
      cwr    = acc && bus.dmem_write_in && bus.dmem_addr[1:0] == 2'd2;
      flush  = cwr && bus.data_from_reg[0];
      push   = 0;
      s_ovf  = 0;
      s_perr = 0;
      s_ferr = 0;
      if (ev_q.size() > 0 && ev_q[0].edge_n == cyc) begin
        if (ev_q[0].kind == 0) push = 1;
        else if (ev_q[0].kind == 1) s_perr = 1;
        else s_ferr = 1;
      end
      if (flush) exp_q.delete();
      else begin
        if (pop) void'(exp_q.pop_front());
        if (push) begin
          if (sz < 16 || pop) exp_q.push_back(ev_q[0].b);
          else s_ovf = 1;
        end
      end
      if (ev_q.size() > 0 && ev_q[0].edge_n == cyc) void'(ev_q.pop_front());
      m_ovf  = s_ovf  || (m_ovf  && !(cwr && bus.data_from_reg[1]));
      m_perr = s_perr || (m_perr && !(cwr && bus.data_from_reg[2]));
      m_ferr = s_ferr || (m_ferr && !(cwr && bus.data_from_reg[3]));
    end
  end

  function automatic logic [31:0] model_status();
    int sz = exp_q.size();
    return (32'(sz) << 16) | (32'(m_ferr) << 4) | (32'(m_perr) << 3) |
           (32'(m_ovf) << 2) | (32'(sz == 16) << 1) | 32'(sz != 0);
  endfunction

  function automatic logic [31:0] model_rdata();
    if (!(bus.sel && bus.dmem_read_in)) return 32'd0;
    case (bus.dmem_addr[1:0])
      2'd0:    return (exp_q.size() > 0) ? (32'h100 | 32'(exp_q[0])) : 32'd0;
      2'd1:    return model_status();
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      chk("rdata", bus.kbd_data_out, model_rdata());
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // ---------------- drivers ----------------
  task automatic bus_idle();
    bus.sel           = 0;
    bus.dmem_read_in  = 0;
    bus.dmem_write_in = 0;
    bus.dmem_addr     = '0;
    bus.data_from_reg = '0;
    bus.stall_in      = 0;
  endtask

  task automatic do_read(input logic [1:0] off, output logic [31:0] d);
    @(negedge clk);
    bus.sel          = 1;
    bus.dmem_read_in = 1;
    bus.dmem_addr    = {28'd0, off};
    bus.stall_in     = 0;
    #1 d = bus.kbd_data_out;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic do_write(input logic [1:0] off, input logic [31:0] v);
    @(negedge clk);
    bus.sel           = 1;
    bus.dmem_write_in = 1;
    bus.dmem_addr     = {28'd0, off};
    bus.data_from_reg = v;
    bus.stall_in      = 0;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int kind);
    ev_t e;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2d = bits[i];
      repeat (H) @(negedge clk);
      ps2c = 0;
      if (i == 10) begin
        e.edge_n = cyc + 4;
        e.kind   = kind;
        e.b      = bits[8:1];
        ev_q.push_back(e);
      end
      repeat (H) @(negedge clk);
      ps2c = 1;
    end
    @(negedge clk);
    ps2d = 1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    logic par;
    int   kind;
    par  = (~^d) ^ bad_par;
    kind = !stop ? 2 : (bad_par ? 1 : 0);
    send_bits({stop, par, d, 1'b0}, 11, kind);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] d;

  initial begin : main
    n_vec = 0;
    n_mis = 0;
    cyc   = 0;
    frames_done = 0;
    ps2c  = 1;
    ps2d  = 1;
    rst_n = 0;
    bus_idle();
    repeat (3) @(negedge clk);
    rst_n = 1;

    do_read(2'd1, d); chk("reset_status", d, 32'h0);
    do_read(2'd0, d); chk("reset_data", d, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // single frame
    send_frame(8'h1C, 0, 1);
    repeat (2) @(negedge clk);
    chk("frame_irq", {31'd0, irq}, 32'd1);
    do_read(2'd1, d); chk("frame_status", d, 32'h0001_0001);
    do_read(2'd0, d); chk("frame_data", d, 32'h0000_011C);
    do_read(2'd1, d); chk("after_pop_status", d, 32'h0);
    chk("after_pop_irq", {31'd0, irq}, 32'd0);
    do_read(2'd0, d); chk("empty_data", d, 32'h0);
    do_read(2'd2, d); chk("ctrl_read", d, 32'h0);

    // parity and framing errors
    send_frame(8'h1C, 1, 1);
    repeat (2) @(negedge clk);
    do_read(2'd1, d); chk("par_err_status", d, 32'h0000_0008);
    send_frame(8'h1C, 0, 0);
    repeat (2) @(negedge clk);
    do_read(2'd1, d); chk("frame_err_status", d, 32'h0000_0018);
    do_write(2'd2, 32'hC);
    do_read(2'd1, d); chk("err_clear_status", d, 32'h0);

    // overflow
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 0, 1);
    repeat (2) @(negedge clk);
    do_read(2'd1, d); chk("ovf_status", d, 32'h0010_0007);
    for (int i = 0; i < 16; i++) begin
      do_read(2'd0, d); chk("ovf_drain", d, 32'h100 + 32'(i));
    end
    do_write(2'd2, 32'h2);
    do_read(2'd1, d); chk("ovf_clear_status", d, 32'h0);

    // aligned push/pop with three queued
    send_frame(8'h21, 0, 1);
    send_frame(8'h22, 0, 1);
    send_frame(8'h23, 0, 1);
    fork
      send_frame(8'h77, 0, 1);
      begin : align
        int guard, e;
        guard = 0;
        while (ev_q.size() == 0 && guard < 500) begin
          @(negedge clk);
          guard++;
        end
        if (ev_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL align_wait: got no frame event expected one within 500 cycles");
        end else begin
          e = ev_q[0].edge_n;
          while (cyc < e - 1) @(negedge clk);
          bus.sel          = 1;
          bus.dmem_read_in = 1;
          bus.dmem_addr    = '0;
          bus.stall_in     = 0;
          @(negedge clk);
          bus_idle();
        end
      end
    join
    repeat (2) @(negedge clk);
    do_read(2'd1, d); chk("push_pop_status", d, 32'h0003_0001);

    // held load under stall pops once
    @(negedge clk);
    bus.sel          = 1;
    bus.dmem_read_in = 1;
    bus.dmem_addr    = '0;
    bus.stall_in     = 1;
    repeat (5) @(negedge clk);
    bus.stall_in = 0;
    #1 d = bus.kbd_data_out;
    @(negedge clk);
    bus_idle();
    chk("stalled_read", d, 32'h0000_0122);
    do_read(2'd1, d); chk("stalled_status", d, 32'h0002_0001);
    do_write(2'd2, 32'h1);
    do_read(2'd1, d); chk("flush_status", d, 32'h0);

    // timeout discards a partial frame
    send_bits(11'b000_0101_0100, 5, 0);
    repeat (TMO + 20) @(negedge clk);
    send_frame(8'h5A, 0, 1);
    repeat (2) @(negedge clk);
    do_read(2'd1, d); chk("timeout_status", d, 32'h0001_0001);
    do_read(2'd0, d); chk("timeout_data", d, 32'h0000_015A);

    // reset in the middle of a frame
    send_frame(8'h11, 0, 1);
    send_bits(11'b000_1110_0110, 6, 0);
    @(negedge clk);
    ps2c  = 1;
    ps2d  = 1;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    do_read(2'd1, d); chk("midreset_status", d, 32'h0);
    chk("midreset_irq", {31'd0, irq}, 32'd0);
    send_frame(8'h3C, 0, 1);
    repeat (2) @(negedge clk);
    do_read(2'd0, d); chk("midreset_data", d, 32'h0000_013C);

    // random frames against random bus traffic
    fork
      begin : rnd_frames
        for (int i = 0; i < 30; i++) begin
          send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 9) != 0));
          repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        frames_done = 1;
      end
      begin : rnd_bus
        int op, it;
        it = 0;
        while (!frames_done && it < 20000) begin
          @(negedge clk);
          it++;
          op = $urandom_range(0, 39);
          bus.stall_in      = ($urandom_range(0, 3) == 0);
          bus.sel           = ($urandom_range(0, 7) != 0);
          bus.dmem_read_in  = (op < 6);
          bus.dmem_write_in = (op == 6);
          bus.dmem_addr     = (op < 2) ? 30'd0 : 30'($urandom_range(0, 3));
          bus.data_from_reg = $urandom;
          if ($urandom_range(0, 3) != 0) bus.data_from_reg[0] = 1'b0;
        end
        @(negedge clk);
        bus_idle();
      end
    join
    for (int i = 0; i < 18; i++) do_read(2'd0, d);
    do_read(2'd1, d);
    chk("final_count", d & 32'h001F_0003, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/kbd_mmio.md
# kbd_mmio

PS/2 keyboard receiver with a scan-code FIFO and a memory-mapped register window, serving the keyboard region (dmem word addresses with `[29:26] == 4'he`) of the CPU data-memory interface. It deserialises PS/2 device-to-host frames, queues valid scan codes, and answers CPU loads and stores with single-cycle combinational read data. It sits beside the data cache and the loader RAM in the data-port address decode and runs on the same `ui_clk` domain.

## Interface
- `FIFO_AW`, 4: FIFO address width; depth is 2**FIFO_AW = 16 entries.
- `TIMEOUT`, 20000: idle `clk` cycles within a frame before the frame is aborted.
- `clk` in 1: system clock (`ui_clk`).
- `rst` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `sel` in 1: address decode hit, driven high when `dmem_addr[29:26] == 4'he`.
- `dmem_read_in` in 1: load request.
- `dmem_write_in` in 1: store request.
- `dmem_addr` in 30: word address; only `[1:0]` is decoded.
- `data_from_reg` in 32: store data.
- `stall_in` in 1: global `mem_stall`. A request is accepted only on a cycle where this signal is low.
- `kbd_data_out` out 32: combinational read data.
- `irq` out 1: registered; high while the FIFO is non-empty.

## Operation
- **Input synchronisation.** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. A third flop holds the previous synchronised `ps2_clk` value. A fall is the condition prev=1 and cur=0. `ps2_data` (synchronised) is sampled on each fall.
- **Receiver FSM.**
  - IDLE: the first fall with data=0 captures the start bit and moves to DATA with `bitcnt`=0. A fall with data=1 is ignored.
  - DATA: 8 falls shift bits in LSB first. After the 8th bit the FSM moves to PAR.
  - PAR: one fall captures the parity bit and moves to STOP.
  - STOP: one fall captures the stop bit and moves to CHECK.
  - CHECK: lasts one cycle, then returns to IDLE.
    - stop=0 sets the sticky `frame_err`.
    - Otherwise, failed odd parity over data+parity sets the sticky `par_err`.
    - Otherwise the byte is pushed.
- **Timeout.** In any non-IDLE state, `TIMEOUT` consecutive cycles without a fall return the FSM to IDLE. Nothing is pushed and no flag is set.
- **Push to a full FIFO.** The byte is dropped and the sticky `ovf` is set.
- **Register map** (accepted = `sel & ~stall_in`).
  - Offset 0, DATA, read: `{23'b0, ~empty, head[7:0]}`. An accepted read while non-empty pops one entry. A read while empty returns 0 and does not pop.
  - Offset 1, STATUS, read:
    - bit 0: `~empty`
    - bit 1: `full`
    - bit 2: `ovf`
    - bit 3: `par_err`
    - bit 4: `frame_err`
    - bits `[16+FIFO_AW:16]`: `count`
    - all other bits: 0
  - Offset 2, CTRL, write. Each action applies when its bit is set:
    - bit 0: flush the FIFO
    - bit 1: clear `ovf`
    - bit 2: clear `par_err`
    - bit 3: clear `frame_err`
    - CTRL reads return 0.
  - Offset 3: reads return 0; writes are ignored. Writes to offsets 0 and 1 are also ignored.
- **Read data gating.** `kbd_data_out` is 0 whenever `sel` or `dmem_read_in` is low.

## Timing
- **Reset** (async, `rst`=0):
  - FSM in IDLE; `bitcnt`, shift register and timeout counter cleared.
  - FIFO pointers and `count` = 0.
  - `ovf`, `par_err`, `frame_err` = 0.
  - `irq` = 0. `kbd_data_out` = 0 because the FIFO is empty.
  - A partially received frame is discarded.
  - Synchroniser flops reset to 1, so no spurious fall occurs after reset.
- **Push latency.** The pin fall of the stop bit is first sampled at clk edge k. Sync stage 2 holds it at edge k+1, and the fall is detected in the cycle after k+1. STOP→CHECK occurs at edge k+2. The push occurs at edge k+3. DATA/`count` reflect the push from edge k+3, and `irq` rises at edge k+4.
- **Pop.** A pop takes effect at the clock edge closing the accepted cycle. The next cycle shows the new head. A held load under `stall_in` pops exactly once.
- **Same-cycle push and pop.** Both occur and `count` is unchanged. A push while full plus a pop in the same cycle is not an overflow: both occur.
- **Flush in the same cycle as a push.** Flush wins; the pushed byte is lost and `ovf` is not set.
- **Clear in the same cycle as a set.** For a sticky flag, set wins.
- **Pointer arithmetic.** Pointers are FIFO_AW bits and wrap modulo depth. `count` is FIFO_AW+1 bits, with 0 ≤ `count` ≤ 16.

## Test plan
- **Single frame.** Reset, then send frame 0x1C with correct odd parity and stop=1. Required: STATUS = 0x0001_0001 and `irq`=1 at the specified edges. A DATA read returns 0x0000_011C. After the pop, STATUS = 0 and `irq`=0, and a second DATA read returns 0.
- **Parity and frame errors.** A frame 0x1C with bad parity sets STATUS bit 3 and does not push. A frame with stop=0 sets bit 4 and does not push. A CTRL write of 0xC clears both flags.
- **Overflow.** Send 17 frames 0x00..0x10. Required: STATUS = 0x0010_0007. Sixteen DATA reads return 0x100..0x10F in order; 0x10 is dropped.
- **Stalled read and simultaneous push/pop.** Hold a DATA read for 5 cycles with `stall_in`=1, then 1 cycle with `stall_in`=0: exactly one pop. With `count`=3, align a push with an accepted pop: `count` stays 3.
- **Timeout and mid-frame reset.** Send 5 bits, then idle for `TIMEOUT` cycles, then send a full frame 0x5A: FIFO holds only 0x5A. Separately, assert `rst` mid-frame: all state clears, and the next full frame is received correctly.
